// File: rtl/gaussian_nb_class_argmax.sv
// Gaussian naive-Bayes class scorer: accumulates per-class feature products
// streamed from an upstream multiplier and reports the highest-scoring class.
// Ties keep the lower class index. Framing errors are flagged in a sticky bit.
module gaussian_nb_class_argmax #(
  parameter int NUM_CLASSES  = 3,
  parameter int NUM_FEATURES = 4,
  parameter int PROD_WIDTH   = 39,
  parameter int ACC_WIDTH    = 48
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [PROD_WIDTH-1:0] prod_in,
  input  logic                         prod_valid,
  input  logic                         prod_last,
  output logic                         mul_ce,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   best_class,
  output logic signed [ACC_WIDTH-1:0]  best_score,
  output logic                         err
);

  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, next_state;

  logic [FW-1:0]               feat_cnt;
  logic [3:0]                  class_idx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [3:0]                  run_class;
  logic signed [ACC_WIDTH-1:0] run_score;

  logic                        accept;
  logic                        last_feat;
  logic                        close_class;
  logic                        final_class;
  logic                        take_best;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;

  // Beat acceptance, class-closing decision and the running-sum adder.
  always_comb begin
    mul_ce      = (state == ACC) || out_ready;
    out_valid   = (state == HOLD);
    accept      = prod_valid && mul_ce;
    last_feat   = (feat_cnt == FW'(NUM_FEATURES - 1));
    close_class = prod_last || last_feat;
    final_class = (class_idx == 4'(NUM_CLASSES - 1));
    base        = (feat_cnt == '0) ? '0 : acc;
    sum         = base + {{(ACC_WIDTH - PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
    take_best   = (class_idx == 4'd0) || (sum > run_score);
  end

  // State register for the accept/hold handshake.
  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= next_state;
  end

  // Next-state logic: enter HOLD after the last class closes, leave on out_ready.
  always_comb begin
    next_state = state;
    case (state)
      ACC:  if (accept && close_class && final_class) next_state = HOLD;
      HOLD: if (out_ready) next_state = ACC;
      default: next_state = ACC;
    endcase
  end

  // Accumulator, counters, running best and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      feat_cnt   <= '0;
      class_idx  <= '0;
      run_class  <= '0;
      run_score  <= '0;
      best_class <= '0;
      best_score <= '0;
      err        <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      if (close_class) begin
        feat_cnt  <= '0;
        class_idx <= final_class ? 4'd0 : class_idx + 4'd1;
        if (prod_last ^ last_feat) err <= 1'b1;
        if (take_best) begin
          run_class <= class_idx;
          run_score <= sum;
        end
        if (final_class) begin
          best_class <= take_best ? class_idx : run_class;
          best_score <= take_best ? sum : run_score;
        end
      end else begin
        feat_cnt <= feat_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gaussian_nb_class_argmax.sv
// Directed bench for gaussian_nb_class_argmax with default parameters.
module tb_gaussian_nb_class_argmax;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [38:0] prod_in;
  logic               prod_valid;
  logic               prod_last;
  logic               mul_ce;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         best_class;
  logic signed [47:0] best_score;
  logic               err;

  int checks = 0;
  int errors = 0;
  int vec [12];

  gaussian_nb_class_argmax dut (
    .clk        (clk),
    .reset      (reset),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .mul_ce     (mul_ce),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_class (best_class),
    .best_score (best_score),
    .err        (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input int p, input logic l);
    prod_valid = v;
    prod_in    = 39'(p);
    prod_last  = l;
    @(posedge clk);
    #1;
  endtask

  // Streams vec[first..11] as three classes of four beats, then idles the bus.
  task automatic send_sample(input int first);
    for (int i = first; i < 12; i++) apply_stimulus(1'b1, vec[i], (i % 4) == 3);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    prod_in    = '0;
  endtask

  task automatic check_result(input string tag, input int cls, input int score);
    check_output({tag, "_valid"}, 64'(out_valid), 1);
    check_output({tag, "_class"}, 64'(best_class), cls);
    check_output({tag, "_score"}, best_score, score);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_valid"}, 64'(out_valid), 0);
    check_output({tag, "_class"}, 64'(best_class), 0);
    check_output({tag, "_score"}, best_score, 0);
    check_output({tag, "_err"}, 64'(err), 0);
    check_output({tag, "_ce"}, 64'(mul_ce), 1);
  endtask

  initial begin
    reset = 1'b1; prod_valid = 1'b0; prod_last = 1'b0; prod_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // Basic sample: sums 100, 96, 100 -> class 0 keeps the tie at 100.
    vec = '{10, 20, 30, 40, -5, 100, 0, 1, 25, 25, 25, 25};
    send_sample(0);
    check_result("basic", 0, 100);
    @(posedge clk); #1;
    check_output("basic_clear", 64'(out_valid), 0);

    // Tie at 50 between classes 0 and 1.
    vec = '{10, 10, 15, 15, 50, 0, 0, 0, 1, 2, 3, 4};
    send_sample(0);
    check_result("tie", 0, 50);
    @(posedge clk); #1;

    // All-negative sums -400, -3, -3.
    vec = '{-100, -100, -100, -100, -1, -1, -1, 0, -3, 0, 0, 0};
    send_sample(0);
    check_result("neg", 1, -3);
    @(posedge clk); #1;

    // Backpressure: sums 4, 8, 14 -> class 2; junk beats during stall must be ignored.
    out_ready = 1'b0;
    vec = '{1, 1, 1, 1, 2, 2, 2, 2, 5, 5, 5, -1};
    send_sample(0);
    check_result("bp", 2, 14);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(1'b1, 1000, 1'b0);
      check_output("bp_ce", 64'(mul_ce), 0);
      check_result("bp_hold", 2, 14);
    end

    // Release in the same cycle as the next sample's first beat.
    vec = '{10, 20, 30, 40, -5, 100, 0, 1, 25, 25, 25, 25};
    out_ready = 1'b1;
    apply_stimulus(1'b1, vec[0], 1'b0);
    check_output("b2b_clear", 64'(out_valid), 0);
    check_output("b2b_ce", 64'(mul_ce), 1);
    send_sample(1);
    check_result("b2b", 0, 100);
    check_output("b2b_err", 64'(err), 0);
    @(posedge clk); #1;

    // Short class: prod_last on the third beat sets the sticky error.
    apply_stimulus(1'b1, 5, 1'b0);
    apply_stimulus(1'b1, 5, 1'b0);
    apply_stimulus(1'b1, 5, 1'b1);
    check_output("err_set", 64'(err), 1);
    apply_stimulus(1'b1, 7, 1'b0);
    apply_stimulus(1'b1, 7, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0);
    check_output("err_sticky", 64'(err), 1);

    // Reset mid-class discards the partial sample.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state("midrst");
    vec = '{-100, -100, -100, -100, -1, -1, -1, 0, -3, 0, 0, 0};
    send_sample(0);
    check_result("post_rst", 1, -3);
    check_output("post_rst_err", 64'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaussian_nb_class_argmax.md
GAUSSIAN_NB_CLASS_ARGMAX -- requirements
Module: gaussian_nb_class_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 3: number of classes scored per sample (legal 2..16).
REQ-002 SHALL have parameter NUM_FEATURES, default 4: products accumulated per class (legal 1..32).
REQ-003 SHALL have parameter PROD_WIDTH, default 39: signed width of the incoming product.
REQ-004 SHALL have parameter ACC_WIDTH, default 48: signed accumulator and score width, at least PROD_WIDTH+5.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port prod_in, input, PROD_WIDTH: signed product from the upstream 16s x 23s multiplier.
REQ-008 SHALL have port prod_valid, input, 1: prod_in carries a valid product this cycle.
REQ-009 SHALL have port prod_last, input, 1: the current beat is the last feature of the current class; meaningful only with prod_valid.
REQ-010 SHALL have port mul_ce, output, 1: clock enable driven to the upstream multiplier and its valid pipeline.
REQ-011 SHALL have port out_valid, output, 1: the result is held.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port best_class, output, 4: index of the winning class.
REQ-014 SHALL have port best_score, output, ACC_WIDTH: signed accumulated score of the winner.
REQ-015 SHALL have port err, output, 1: sticky framing error flag.

Function
REQ-016 SHALL have two states: ACC (accepting products) and HOLD (result pending).
REQ-017 SHALL accept a beat only when prod_valid=1 and mul_ce=1; all other cycles leave internal state unchanged.
REQ-018 SHALL drive mul_ce=1 in ACC, and in HOLD only while out_ready=1, so the upstream multiplier freezes while a result is unaccepted.
REQ-019 SHALL compute sum = (first beat of class ? 0 : acc) + sign_extend(prod_in) to ACC_WIDTH on each accepted beat, with no saturation.
REQ-020 SHALL keep a feature counter that increments per accepted beat and clears on prod_last.
REQ-021 SHALL, on an accepted beat with prod_last=1, update best to {class_idx, sum} if class_idx=0 or sum is strictly greater than best_score (signed compare); ties keep the lower index.
REQ-022 SHALL, on the prod_last beat of class NUM_CLASSES-1, register the final best_class and best_score, set out_valid=1 on the next cycle, enter HOLD, and wrap class_idx to 0.
REQ-023 SHALL have a latency of one cycle from the final accepted beat to out_valid=1.
REQ-024 SHALL hold best_class and best_score stable while out_valid=1.
REQ-025 SHALL, in HOLD with out_ready=1, clear out_valid on the next cycle and return to ACC.
REQ-026 SHALL, in HOLD with out_ready=1, also accept a beat presented in that same cycle as the first beat of the next sample, giving zero bubble.
REQ-027 SHALL set err when prod_last arrives with feature count not equal to NUM_FEATURES-1, or when NUM_FEATURES beats arrive without prod_last.
REQ-028 SHALL, on that error, still close the class as if prod_last were at the offending beat; err stays set until reset.
REQ-029 SHALL treat NUM_FEATURES=1 as every accepted beat requiring prod_last=1.

Reset
REQ-030 SHALL, when reset=1 on a clock edge, set state=ACC, out_valid=0, best_class=0, best_score=0, err=0, acc=0, class_idx=0, feature count=0, and mul_ce=1 in the following cycle.
REQ-031 SHALL let reset override all inputs, including mid-sample and in HOLD, and discard any partial sample.

Verification
REQ-032 Defaults, sample products class0 {10,20,30,40}, class1 {-5,100,0,1}, class2 {25,25,25,25}, prod_last on each 4th beat, out_ready=1 -> one cycle after the last beat out_valid=1, best_class=0, best_score=100.
REQ-033 Tie: class0 sum 50, class1 sum 50, class2 sum 10 -> best_class=0, best_score=50.
REQ-034 All-negative: sums -400, -3, -3 -> best_class=1, best_score=-3 (signed compare, strict greater).
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid -> mul_ce=0 and outputs stable for those cycles; out_ready=1 -> out_valid=0 on the next cycle and mul_ce=1.
REQ-036 Back-to-back: the next sample's first beat arrives in the out_ready=1 cycle -> it is accepted, and the second result is correct.
REQ-037 Errors and reset: prod_last on the 3rd beat -> err=1 and stays 1; reset asserted mid-class -> all outputs return to reset values and the next full sample scores correctly.
